// File: rtl/led_chase_pkg.sv
// Shared encodings for the LED chase sequencer.
//   MODE_* : 2-bit direction mode select
//   state_e: run/stop FSM states
//   DIR_*  : ping-pong direction flag values
package led_chase_pkg;

   localparam int unsigned IDX_W = 4;

   localparam logic [1:0] MODE_UP   = 2'b00;
   localparam logic [1:0] MODE_DOWN = 2'b01;
   localparam logic [1:0] MODE_PP   = 2'b10;
   localparam logic [1:0] MODE_HOLD = 2'b11;

   typedef enum logic {
      S_STOP = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   localparam logic [IDX_W-1:0] IDX_MIN = 4'h0;
   localparam logic [IDX_W-1:0] IDX_MAX = 4'hF;

endpackage

// File: rtl/led_chase_seq_prescaler.sv
// Step prescaler: free-running 0..DIV-1 counter while run=1, held at 0 otherwise.
//   clk, rst : clock, async active-high reset
//   run      : count enable; low clears the counter
//   strobe   : high for the one cycle where count == DIV-1 (and run is high)
module step_prescaler #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic strobe
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // Counter wraps at DIV-1; dropping run clears it so the next run starts a full period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!run) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Gated by run so the stop cycle never issues a step
   assign strobe = run && (cnt == LAST);

endmodule

// File: rtl/led_chase_seq.sv
// LED chase sequencer: drives the 4-bit select of a 4-to-16 one-hot LED decoder.
//   clk, rst  : clock, async active-high reset (release assumed synchronous to clk)
//   en        : 1 = free-run at STEP_HZ, 0 = stopped
//   mode      : 00 up, 01 down, 10 ping-pong, 11 hold
//   step_req  : single-cycle pulse, one step while stopped
//   a,b,c,d   : index[3:0], MSB first, straight from flops
//   tick      : one-cycle pulse coincident with each index change
module led_chase_seq
   import led_chase_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned STEP_HZ     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] mode,
   input  logic       step_req,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic       tick
);

   localparam int unsigned DIV = CLK_FREQ_HZ / STEP_HZ;

   state_e           state, state_nx;
   logic [IDX_W-1:0] index, index_nx;
   logic             dir, dir_nx;
   logic             tick_nx;
   logic             strobe;
   logic             step;

   step_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .run    ((state == S_RUN) && en),
      .strobe (strobe)
   );

   // Manual step only while stopped and not simultaneously starting
   assign step = strobe || ((state == S_STOP) && !en && step_req);

   // State, index, direction and tick registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_STOP;
         index <= '0;
         dir   <= DIR_UP;
         tick  <= 1'b0;
      end else begin
         state <= state_nx;
         index <= index_nx;
         dir   <= dir_nx;
         tick  <= tick_nx;
      end
   end

   // Next-state and step rule; mode is only looked at on a step cycle
   always_comb begin
      state_nx = state;
      index_nx = index;
      dir_nx   = dir;
      tick_nx  = 1'b0;

      case (state)
         S_STOP:  if (en)  state_nx = S_RUN;
         S_RUN:   if (!en) state_nx = S_STOP;
         default: state_nx = S_STOP;
      endcase

      if (step) begin
         case (mode)
            MODE_UP: begin
               index_nx = index + IDX_W'(1);
               tick_nx  = 1'b1;
            end
            MODE_DOWN: begin
               index_nx = index - IDX_W'(1);
               tick_nx  = 1'b1;
            end
            MODE_PP: begin
               // Ends force the direction so no end value is ever repeated
               if (index == IDX_MAX) begin
                  dir_nx   = DIR_DOWN;
                  index_nx = index - IDX_W'(1);
               end else if (index == IDX_MIN) begin
                  dir_nx   = DIR_UP;
                  index_nx = index + IDX_W'(1);
               end else if (dir == DIR_UP) begin
                  index_nx = index + IDX_W'(1);
               end else begin
                  index_nx = index - IDX_W'(1);
               end
               tick_nx = 1'b1;
            end
            default: begin
               index_nx = index;
            end
         endcase
      end
   end

   assign a = index[3];
   assign b = index[2];
   assign c = index[1];
   assign d = index[0];

endmodule

// File: tb/tb_led_chase_seq.sv
// Self-checking bench for led_chase_seq (DIV = 4) against an integer behavioural model.
module tb_led_chase_seq;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic       step_req;
   logic       a, b, c, d, tick;

   int n_checks = 0;
   int n_fail   = 0;
   int dut_ticks = 0;

   // Behavioural model: plain integers, direction as +1/-1
   int m_idx, m_dir, m_cnt, m_steps;
   bit m_run, m_tick;

   led_chase_seq #(
      .CLK_FREQ_HZ (16),
      .STEP_HZ     (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .step_req (step_req),
      .a        (a),
      .b        (b),
      .c        (c),
      .d        (d),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_idx = 0; m_dir = 1; m_cnt = 0; m_run = 0; m_tick = 0;
   endtask

   // One clock edge of the reference behaviour, using the inputs present at that edge
   task automatic model_edge();
      bit do_step;
      do_step = 0;
      m_tick  = 0;
      if (rst) begin
         model_reset();
      end else begin
         if (m_run) begin
            if (!en) begin
               m_run = 0; m_cnt = 0;
            end else if (m_cnt == DIV - 1) begin
               m_cnt = 0; do_step = 1;
            end else begin
               m_cnt++;
            end
         end else if (en) begin
            m_run = 1; m_cnt = 0;
         end else if (step_req) begin
            do_step = 1;
         end
         if (do_step) begin
            case (int'(mode))
               0: begin m_idx = (m_idx + 1) % 16;  m_tick = 1; end
               1: begin m_idx = (m_idx + 15) % 16; m_tick = 1; end
               2: begin
                  if (m_idx == 15) m_dir = -1;
                  else if (m_idx == 0) m_dir = 1;
                  m_idx  = m_idx + m_dir;
                  m_tick = 1;
               end
               default: ;
            endcase
            if (m_tick) m_steps++;
         end
      end
   endtask

   // Advance one clock, update the model, then compare just after the edge
   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      if (tick) dut_ticks++;
      check("idx", int'({a, b, c, d}), m_idx);
      check("tick", int'(tick), int'(m_tick));
   endtask

   task automatic run_steps(input int n);
      int s0;
      s0 = m_steps;
      for (int i = 0; i < 64 * n && m_steps < s0 + n; i++) cyc();
      check("step_budget", m_steps - s0, n);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s0, s1, t0, prev;
      int pp_exp[18];

      rst = 1'b1; en = 1'b0; mode = 2'b00; step_req = 1'b0;
      model_reset();
      m_steps = 0;
      #12;
      check("reset_idx", int'({a, b, c, d}), 0);
      check("reset_tick", int'(tick), 0);
      rst = 1'b0;

      // 1. Async reset mid-run at index 9
      en = 1'b1; mode = 2'b00;
      for (int i = 0; i < 200 && m_idx != 9; i++) cyc();
      check("reach_9", int'({a, b, c, d}), 9);
      #2; rst = 1'b1;
      #1;
      check("rst_async_idx", int'({a, b, c, d}), 0);
      check("rst_async_tick", int'(tick), 0);
      cyc(); cyc();
      en = 1'b0;
      #2; rst = 1'b0;
      repeat (8) cyc();
      check("rst_hold_idx", int'({a, b, c, d}), 0);

      // 2. Up run: first step DIV edges after en is seen
      mode = 2'b00; en = 1'b1;
      s0 = m_steps;
      repeat (5) cyc();
      check("first_step", int'({a, b, c, d}), 1);
      check("first_tick", int'(tick), 1);
      cyc();
      check("tick_one_cycle", int'(tick), 0);
      repeat (3) cyc();
      check("second_step", int'({a, b, c, d}), 2);
      run_steps(14);
      check("up_wrap_16", int'({a, b, c, d}), 0);
      check("up_16_steps", m_steps - s0, 16);

      // 3. Down run from 0
      mode = 2'b01;
      run_steps(1);
      check("down_first", int'({a, b, c, d}), 15);
      run_steps(1);
      check("down_second", int'({a, b, c, d}), 14);
      s1 = m_steps; t0 = dut_ticks;
      repeat (40) cyc();
      check("down_tick_count", dut_ticks - t0, m_steps - s1);

      // 4. Ping-pong from 13
      for (int i = 0; i < 200 && m_idx != 13; i++) cyc();
      check("reach_13", int'({a, b, c, d}), 13);
      mode = 2'b10;
      pp_exp[0] = 14; pp_exp[1] = 15;
      for (int k = 0; k < 15; k++) pp_exp[2 + k] = 14 - k;
      pp_exp[17] = 1;
      prev = 13;
      for (int k = 0; k < 18; k++) begin
         run_steps(1);
         check("pp_seq", int'({a, b, c, d}), pp_exp[k]);
         check("pp_moved", int'(int'({a, b, c, d}) != prev), 1);
         prev = int'({a, b, c, d});
      end

      // 5. Stop and single-step
      mode = 2'b00;
      for (int i = 0; i < 200 && m_idx != 5; i++) cyc();
      check("reach_5", int'({a, b, c, d}), 5);
      en = 1'b0;
      t0 = dut_ticks;
      repeat (50) cyc();
      check("stop_hold_idx", int'({a, b, c, d}), 5);
      check("stop_no_tick", dut_ticks - t0, 0);
      for (int k = 0; k < 3; k++) begin
         step_req = 1'b1;
         cyc();
         step_req = 1'b0;
         check("step_idx", int'({a, b, c, d}), 6 + k);
         check("step_tick", int'(tick), 1);
         repeat (3) cyc();
      end
      step_req = 1'b1; en = 1'b1;
      cyc();
      step_req = 1'b0;
      check("step_with_en", int'({a, b, c, d}), 8);
      repeat (2) cyc();
      check("step_with_en_later", int'({a, b, c, d}), 8);

      // 6. Hold, then switch to up mid-prescale
      mode = 2'b11;
      t0 = dut_ticks;
      repeat (20) cyc();
      check("hold_idx", int'({a, b, c, d}), 8);
      check("hold_no_tick", dut_ticks - t0, 0);
      for (int i = 0; i < 8 && m_cnt != 1; i++) cyc();
      check("hold_phase", m_cnt, 1);
      mode = 2'b00;
      cyc();
      check("switch_not_early", int'({a, b, c, d}), 8);
      run_steps(1);
      check("switch_step", int'({a, b, c, d}), 9);

      // Randomised soak against the model
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) en = ~en;
         if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
         step_req = ($urandom_range(0, 5) == 0);
         cyc();
      end
      step_req = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
